// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one single-ported L1 cache SRAM between fetch and data requesters,
// with a fixed-latency read return path and a drain handshake. Optional counters: CACHE_ARB_PERF_EN.
module cache_port_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned WORD_W = 64,
  parameter int unsigned RD_LAT = 2,
  localparam int unsigned WEN_W = DATA_W / WORD_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_rsp_valid,
  output logic [DATA_W-1:0] i_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_write,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  input  logic [WEN_W-1:0]  d_req_wen,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              cache_isReadData,
  output logic [ADDR_W-1:0] cache_rwAddr,
  output logic [DATA_W-1:0] cache_writeData,
  output logic [WEN_W-1:0]  cache_writeEnable,
  input  logic [DATA_W-1:0] cache_readData,
  input  logic              drain_req,
  output logic              drain_done
`ifdef CACHE_ARB_PERF_EN
  ,
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_conflicts
`endif
);

  typedef enum logic [1:0] {StRun, StDrain, StHold} state_e;

  state_e state_q, state_d;
  // 1: the data requester won the most recent transfer
  logic last_d_q, last_d_d;

  logic              is_read_q, is_read_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WEN_W-1:0]  wen_q, wen_d;

  // {valid,id} follows each read; id 1 = data requester
  logic [RD_LAT:0] tag_v_q, tag_id_q;

  logic accept, i_xfer, d_xfer, rd_xfer, pipe_busy;

  assign accept      = (state_q == StRun) && !drain_req;
  assign i_req_ready = accept && i_req_valid && (!d_req_valid || last_d_q);
  assign d_req_ready = accept && d_req_valid && (!i_req_valid || !last_d_q);
  assign i_xfer      = i_req_ready;
  assign d_xfer      = d_req_ready;
  assign rd_xfer     = i_xfer || (d_xfer && !d_req_write);

  // The oldest tag stage retires this cycle, so it does not hold off the drain.
  assign pipe_busy = (|tag_v_q[RD_LAT-1:0]) || (|wen_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (drain_req) state_d = StDrain;
      StDrain: if (!pipe_busy) state_d = StHold;
      StHold:  if (!drain_req) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    last_d_d  = last_d_q;
    is_read_d = 1'b0;
    wen_d     = '0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if (i_xfer) begin
      last_d_d  = 1'b0;
      is_read_d = 1'b1;
      addr_d    = i_req_addr;
    end else if (d_xfer) begin
      last_d_d = 1'b1;
      addr_d   = d_req_addr;
      if (d_req_write) begin
        wdata_d = d_req_wdata;
        wen_d   = d_req_wen;
      end else begin
        is_read_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StRun;
      last_d_q  <= 1'b1;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wen_q     <= '0;
      tag_v_q   <= '0;
      tag_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wen_q     <= wen_d;
      tag_v_q   <= {tag_v_q[RD_LAT-1:0], rd_xfer};
      tag_id_q  <= {tag_id_q[RD_LAT-1:0], d_xfer};
    end
  end

  assign cache_isReadData  = is_read_q;
  assign cache_rwAddr      = addr_q;
  assign cache_writeData   = wdata_q;
  assign cache_writeEnable = wen_q;

  assign i_rsp_valid = tag_v_q[RD_LAT] && !tag_id_q[RD_LAT];
  assign d_rsp_valid = tag_v_q[RD_LAT] && tag_id_q[RD_LAT];
  assign i_rsp_data  = i_rsp_valid ? cache_readData : '0;
  assign d_rsp_data  = d_rsp_valid ? cache_readData : '0;
  assign drain_done  = (state_q == StHold);

`ifdef CACHE_ARB_PERF_EN
  logic conflict;
  assign conflict = (state_q == StRun) && i_req_valid && d_req_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else begin
      if (i_xfer && (perf_i_grants != 32'hFFFF_FFFF)) perf_i_grants <= perf_i_grants + 32'd1;
      if (d_xfer && (perf_d_grants != 32'hFFFF_FFFF)) perf_d_grants <= perf_d_grants + 32'd1;
      if (conflict && (perf_conflicts != 32'hFFFF_FFFF)) begin
        perf_conflicts <= perf_conflicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench for cache_port_arbiter: a latency-accurate cache model plus a response
// scoreboard; perf counters are exercised when CACHE_ARB_PERF_EN is defined.
module tb_cache_port_arbiter;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned WORD_W = 64;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned WEN_W  = DATA_W / WORD_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              i_req_valid = 1'b0, i_req_ready;
  logic [ADDR_W-1:0] i_req_addr = '0;
  logic              i_rsp_valid;
  logic [DATA_W-1:0] i_rsp_data;
  logic              d_req_valid = 1'b0, d_req_ready, d_req_write = 1'b0;
  logic [ADDR_W-1:0] d_req_addr = '0;
  logic [DATA_W-1:0] d_req_wdata = '0;
  logic [WEN_W-1:0]  d_req_wen = '0;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_data;
  logic              cache_isReadData;
  logic [ADDR_W-1:0] cache_rwAddr;
  logic [DATA_W-1:0] cache_writeData;
  logic [WEN_W-1:0]  cache_writeEnable;
  logic [DATA_W-1:0] cache_readData;
  logic              drain_req = 1'b0, drain_done;
`ifdef CACHE_ARB_PERF_EN
  logic [31:0] perf_i_grants, perf_d_grants, perf_conflicts;
`endif

  cache_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORD_W(WORD_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_write(d_req_write),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_wen(d_req_wen),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .cache_isReadData(cache_isReadData), .cache_rwAddr(cache_rwAddr),
    .cache_writeData(cache_writeData), .cache_writeEnable(cache_writeEnable),
    .cache_readData(cache_readData),
    .drain_req(drain_req), .drain_done(drain_done)
`ifdef CACHE_ARB_PERF_EN
    ,
    .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
    .perf_conflicts(perf_conflicts)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] cdata(input logic [ADDR_W-1:0] a);
    return {a ^ 64'h5A5A_5A5A_5A5A_5A5A, ~a};
  endfunction

  // Cache model: data for the address read in cycle C appears in cycle C+RD_LAT.
  logic [DATA_W-1:0] cpipe [RD_LAT];
  always @(posedge clk) begin
    cpipe[0] <= cache_isReadData ? cdata(cache_rwAddr) : 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    for (int k = 1; k < int'(RD_LAT); k++) cpipe[k] <= cpipe[k-1];
  end
  assign cache_readData = cpipe[RD_LAT-1];

  typedef struct {
    int              due;
    bit              id;
    logic [DATA_W-1:0] data;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response monitor: checks every cycle against the scoreboard head.
  always @(negedge clk) begin
    if (reset_n) begin
      bit exp_iv, exp_dv;
      logic [DATA_W-1:0] exp_data;
      exp_iv = 1'b0;
      exp_dv = 1'b0;
      exp_data = '0;
      while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        exp_iv = !e.id;
        exp_dv = e.id;
        exp_data = e.data;
      end
      check("i_rsp_valid", i_rsp_valid, exp_iv);
      check("d_rsp_valid", d_rsp_valid, exp_dv);
      check("i_rsp_data", i_rsp_data, exp_iv ? exp_data : '0);
      check("d_rsp_data", d_rsp_data, exp_dv ? exp_data : '0);
    end
  end

  task automatic step(input bit iv, input logic [ADDR_W-1:0] ia, input bit dv, input bit dw,
                      input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] wd,
                      input logic [WEN_W-1:0] wen, input bit drn,
                      input bit ei, input bit ed, input bit edone);
    @(posedge clk);
    #1;
    i_req_valid = iv;
    i_req_addr  = ia;
    d_req_valid = dv;
    d_req_write = dw;
    d_req_addr  = da;
    d_req_wdata = wd;
    d_req_wen   = wen;
    drain_req   = drn;
    #1;
    check("i_req_ready", i_req_ready, ei);
    check("d_req_ready", d_req_ready, ed);
    check("drain_done", drain_done, edone);
    if (ei) sb.push_back('{cyc + 1 + int'(RD_LAT), 1'b0, cdata(ia)});
    if (ed && !dw) sb.push_back('{cyc + 1 + int'(RD_LAT), 1'b1, cdata(da)});
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, '0, 0, 0, '0, '0, '0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    drain_req = 1'b0;
    sb.delete();
    #1;
    check("rst_isread", cache_isReadData, 0);
    check("rst_addr", cache_rwAddr, 0);
    check("rst_wdata", cache_writeData, 0);
    check("rst_wen", cache_writeEnable, 0);
    check("rst_i_rsp", i_rsp_valid, 0);
    check("rst_d_rsp", d_rsp_valid, 0);
    check("rst_drain_done", drain_done, 0);
`ifdef CACHE_ARB_PERF_EN
    check("rst_perf_i", perf_i_grants, 0);
    check("rst_perf_d", perf_d_grants, 0);
    check("rst_perf_c", perf_conflicts, 0);
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Single fetch: issue at T+1, response at T+3.
    step(1, 64'h1000, 0, 0, '0, '0, '0, 0, 1, 0, 0);
    idle(1);
    check("fetch_isread", cache_isReadData, 1);
    check("fetch_addr", cache_rwAddr, 64'h1000);
    check("fetch_wen", cache_writeEnable, 0);
    idle(1);
    check("idle_isread", cache_isReadData, 0);
    check("idle_addr_hold", cache_rwAddr, 64'h1000);
    idle(4);

    // Conflicts from reset: I, D, I, D.
    do_reset();
    step(1, 64'h100, 1, 0, 64'h200, '0, '0, 0, 1, 0, 0);
    step(1, 64'h110, 1, 0, 64'h210, '0, '0, 0, 0, 1, 0);
    step(1, 64'h120, 1, 0, 64'h220, '0, '0, 0, 1, 0, 0);
    step(1, 64'h130, 1, 0, 64'h230, '0, '0, 0, 0, 1, 0);
    idle(5);

    // Store: one-cycle write, no response.
    step(0, '0, 1, 1, 64'h40, {16{8'hA5}}, 2'b10, 0, 0, 1, 0);
    idle(1);
    check("st_isread", cache_isReadData, 0);
    check("st_wen", cache_writeEnable, 2'b10);
    check("st_wdata", cache_writeData, {16{8'hA5}});
    check("st_addr", cache_rwAddr, 64'h40);
    idle(1);
    check("st_wen_off", cache_writeEnable, 0);
    idle(4);

    // Load then drain at T+1.
    step(0, '0, 1, 0, 64'h2000, '0, '0, 0, 0, 1, 0);
    step(1, 64'h3000, 0, 0, '0, '0, '0, 1, 0, 0, 0);
    step(1, 64'h3000, 0, 0, '0, '0, '0, 1, 0, 0, 0);
    step(1, 64'h3000, 0, 0, '0, '0, '0, 1, 0, 0, 0);
    step(1, 64'h3000, 0, 0, '0, '0, '0, 1, 0, 0, 1);
    step(1, 64'h3000, 0, 0, '0, '0, '0, 0, 0, 0, 1);
    step(1, 64'h3000, 0, 0, '0, '0, '0, 0, 1, 0, 0);
    idle(5);

    // Drain with an empty pipeline: done two cycles after the request.
    step(0, '0, 0, 0, '0, '0, '0, 1, 0, 0, 0);
    step(0, '0, 0, 0, '0, '0, '0, 1, 0, 0, 0);
    step(0, '0, 0, 0, '0, '0, '0, 1, 0, 0, 1);
    step(0, '0, 0, 0, '0, '0, '0, 0, 0, 0, 1);
    idle(2);

    // Reset one cycle after a fetch: read is discarded; fetch wins next conflict.
    step(1, 64'h5000, 0, 0, '0, '0, '0, 0, 1, 0, 0);
    do_reset();
    idle(6);
    step(1, 64'h6000, 1, 0, 64'h7000, '0, '0, 0, 1, 0, 0);
    idle(5);

    // Random traffic against a round-robin model.
    do_reset();
    begin
      bit mlast;
      mlast = 1'b1;
      for (int n = 0; n < 60; n++) begin
        bit iv, dv, dw, ei, ed;
        iv = 1'($urandom_range(0, 1));
        dv = 1'($urandom_range(0, 1));
        dw = 1'($urandom_range(0, 3) == 0);
        ei = iv && (!dv || mlast);
        ed = dv && (!iv || !mlast);
        if (ei) mlast = 1'b0;
        else if (ed) mlast = 1'b1;
        step(iv, {$urandom, $urandom}, dv, dw, {$urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, 2'($urandom_range(0, 3)), 0, ei, ed, 0);
      end
    end
    idle(5);

`ifdef CACHE_ARB_PERF_EN
    do_reset();
    for (int n = 0; n < 10; n++) begin
      step(1, 64'h8000 + 64'(n), 1, 0, 64'h9000 + 64'(n), '0, '0, 0, n % 2 == 0, n % 2 == 1, 0);
    end
    idle(2);
    check("perf_conflicts", perf_conflicts, 10);
    check("perf_i_grants", perf_i_grants, 5);
    check("perf_d_grants", perf_d_grants, 5);
    idle(4);
`endif

    idle(3);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
